// File: rtl/tf_pkg.sv
// Shared types, lamp codes and helpers for the multi-direction traffic-light controller.
package tf_pkg;

  typedef enum logic [1:0] {
    ALLRED = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2,
    NIGHT  = 2'd3
  } tf_state_e;

  localparam logic [2:0] LAMP_R   = 3'b100;
  localparam logic [2:0] LAMP_Y   = 3'b010;
  localparam logic [2:0] LAMP_G   = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  function automatic int unsigned sat_add(input int unsigned a, input int unsigned b,
                                          input int unsigned max_v);
    int unsigned s;
    s = a + b;
    return (s > max_v) ? max_v : s;
  endfunction

endpackage

// File: rtl/tf_display_map.sv
// Maps controller state/direction/countdown onto per-direction lamp codes and countdowns.
module tf_display_map
  import tf_pkg::*;
#(
  parameter int N_DIR    = 2,
  parameter int TW       = 7,
  parameter int YELLOW_T = 3,
  parameter int ALLRED_T = 2
) (
  input  tf_state_e              state_i,
  input  logic [1:0]             cur_i,
  input  logic [TW-1:0]          cnt_i,
  input  logic                   blink_i,
  output logic [3*N_DIR-1:0]     tf_o,
  output logic [TW*N_DIR-1:0]    timer_o
);

  localparam int unsigned TMAX = (1 << TW) - 1;

  logic [1:0] nxt_s;
  assign nxt_s = (cur_i == 2'(N_DIR - 1)) ? 2'd0 : cur_i + 2'd1;

  // The next direction shows the time remaining until its own green begins.
  always_comb begin
    tf_o    = '0;
    timer_o = '0;
    for (int d = 0; d < N_DIR; d++) begin
      tf_o[3*d +: 3]      = LAMP_R;
      timer_o[TW*d +: TW] = '0;
      case (state_i)
        GREEN: begin
          if (2'(d) == cur_i) begin
            tf_o[3*d +: 3]      = LAMP_G;
            timer_o[TW*d +: TW] = cnt_i;
          end else if (2'(d) == nxt_s) begin
            timer_o[TW*d +: TW] = TW'(sat_add(32'(cnt_i), 32'(YELLOW_T + ALLRED_T), TMAX));
          end else begin
            timer_o[TW*d +: TW] = '0;
          end
        end
        YELLOW: begin
          if (2'(d) == cur_i) begin
            tf_o[3*d +: 3]      = LAMP_Y;
            timer_o[TW*d +: TW] = cnt_i;
          end else if (2'(d) == nxt_s) begin
            timer_o[TW*d +: TW] = TW'(sat_add(32'(cnt_i), 32'(ALLRED_T), TMAX));
          end else begin
            timer_o[TW*d +: TW] = '0;
          end
        end
        ALLRED: begin
          if (2'(d) == nxt_s) begin
            timer_o[TW*d +: TW] = cnt_i;
          end else begin
            timer_o[TW*d +: TW] = '0;
          end
        end
        NIGHT: begin
          tf_o[3*d +: 3] = blink_i ? LAMP_Y : LAMP_OFF;
        end
        default: begin
          tf_o[3*d +: 3] = LAMP_R;
        end
      endcase
    end
  end

endmodule

// File: rtl/tf_ctl_multi.sv
// Round-robin traffic-light controller for N_DIR approaches with night flashing
// and emergency preemption; all state advances only on TICK.
module tf_ctl_multi
  import tf_pkg::*;
#(
  parameter int N_DIR    = 2,
  parameter int TW       = 7,
  parameter int GREEN_T  = 30,
  parameter int YELLOW_T = 3,
  parameter int ALLRED_T = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  TICK,
  input  logic                  NIGHT,
  input  logic                  EMG,
  input  logic [1:0]            EMG_DIR,
  output logic [3*N_DIR-1:0]    TF,
  output logic [TW*N_DIR-1:0]   TIMER,
  output logic [1:0]            PHASE,
  output logic [1:0]            CUR_DIR
);

  if (N_DIR < 2 || N_DIR > 4 || GREEN_T < 1 || YELLOW_T < 1 || ALLRED_T < 1 ||
      GREEN_T >= (1 << TW) || YELLOW_T >= (1 << TW) || ALLRED_T >= (1 << TW)) begin : g_bad_param
    $error("tf_ctl_multi: illegal parameter combination");
  end

  localparam logic [1:0]    LAST_DIR = 2'(N_DIR - 1);
  localparam logic [TW-1:0] GREEN_C  = TW'(GREEN_T);
  localparam logic [TW-1:0] YELLOW_C = TW'(YELLOW_T);
  localparam logic [TW-1:0] ALLRED_C = TW'(ALLRED_T);

  tf_state_e     state_q;
  logic [1:0]    cur_q;
  logic [TW-1:0] cnt_q;
  logic          blink_q;
  logic          held_q;

  logic          emg_s;
  logic          expire_s;
  logic [1:0]    nxt_s;

  // An out-of-range emergency direction is treated as no request at all.
  assign emg_s    = EMG && ({1'b0, EMG_DIR} < 3'(N_DIR));
  assign expire_s = (cnt_q <= TW'(1));
  assign nxt_s    = (cur_q == LAST_DIR) ? 2'd0 : cur_q + 2'd1;

  // Phase sequencer and countdown; held_q remembers a preempted green for reload on release.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= tf_pkg::ALLRED;
      cur_q   <= LAST_DIR;
      cnt_q   <= ALLRED_C;
      blink_q <= 1'b0;
      held_q  <= 1'b0;
    end else if (TICK) begin
      case (state_q)
        tf_pkg::ALLRED: begin
          if (!expire_s) begin
            cnt_q <= cnt_q - TW'(1);
          end else if (emg_s) begin
            state_q <= tf_pkg::GREEN;
            cur_q   <= EMG_DIR;
            cnt_q   <= GREEN_C;
          end else if (NIGHT) begin
            state_q <= tf_pkg::NIGHT;
            cnt_q   <= '0;
            blink_q <= 1'b1;
          end else begin
            state_q <= tf_pkg::GREEN;
            cur_q   <= nxt_s;
            cnt_q   <= GREEN_C;
          end
        end
        tf_pkg::GREEN: begin
          if (emg_s && (EMG_DIR == cur_q)) begin
            held_q <= 1'b1;
          end else if (emg_s || NIGHT) begin
            state_q <= tf_pkg::YELLOW;
            cnt_q   <= YELLOW_C;
            held_q  <= 1'b0;
          end else if (held_q) begin
            cnt_q  <= GREEN_C;
            held_q <= 1'b0;
          end else if (!expire_s) begin
            cnt_q <= cnt_q - TW'(1);
          end else begin
            state_q <= tf_pkg::YELLOW;
            cnt_q   <= YELLOW_C;
          end
        end
        tf_pkg::YELLOW: begin
          if (!expire_s) begin
            cnt_q <= cnt_q - TW'(1);
          end else begin
            state_q <= tf_pkg::ALLRED;
            cnt_q   <= ALLRED_C;
          end
        end
        tf_pkg::NIGHT: begin
          if (emg_s || !NIGHT) begin
            state_q <= tf_pkg::ALLRED;
            cur_q   <= LAST_DIR;
            cnt_q   <= ALLRED_C;
            blink_q <= 1'b0;
          end else begin
            blink_q <= ~blink_q;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= tf_pkg::ALLRED;
          cur_q   <= LAST_DIR;
          cnt_q   <= ALLRED_C;
          blink_q <= 1'b0;
          held_q  <= 1'b0;
        end
      endcase
    end
  end

  tf_display_map #(
    .N_DIR    (N_DIR),
    .TW       (TW),
    .YELLOW_T (YELLOW_T),
    .ALLRED_T (ALLRED_T)
  ) u_map (
    .state_i (state_q),
    .cur_i   (cur_q),
    .cnt_i   (cnt_q),
    .blink_i (blink_q),
    .tf_o    (TF),
    .timer_o (TIMER)
  );

  assign PHASE   = state_q;
  assign CUR_DIR = cur_q;

endmodule

// File: tb/tb_tf_ctl_multi.sv
// Bench for tf_ctl_multi: 2- and 3-direction instances, vector table, corner sequences
// and randomized inputs against a behavioural model.
module tb_tf_ctl_multi;

  localparam int GT = 30;
  localparam int YT = 3;
  localparam int AT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
  logic night = 1'b0;
  logic emg = 1'b0;
  logic [1:0] emg_dir = 2'd0;

  logic [5:0]  tf2;
  logic [13:0] tm2;
  logic [1:0]  ph2, cd2;
  logic [8:0]  tf3;
  logic [20:0] tm3;
  logic [1:0]  ph3, cd3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tf_ctl_multi u_dut2 (
    .CLK(clk), .RST(rst), .TICK(tick), .NIGHT(night), .EMG(emg), .EMG_DIR(emg_dir),
    .TF(tf2), .TIMER(tm2), .PHASE(ph2), .CUR_DIR(cd2)
  );

  tf_ctl_multi #(.N_DIR(3)) u_dut3 (
    .CLK(clk), .RST(rst), .TICK(tick), .NIGHT(night), .EMG(emg), .EMG_DIR(emg_dir),
    .TF(tf3), .TIMER(tm3), .PHASE(ph3), .CUR_DIR(cd3)
  );

  // Model: phase code (0 allred, 1 green, 2 yellow, 3 night), owner, remaining ticks.
  typedef struct {
    int ph;
    int cur;
    int cnt;
    int blink;
    int held;
  } mdl_t;

  mdl_t m2, m3;

  typedef struct {
    bit night;
    bit emg;
    int edir;
    int n;
    int tf;
    int t0;
    int t1;
    int ph;
    int cur;
  } vec_t;

  vec_t vt[26];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic mdl_t mdl_reset(input int n);
    mdl_t r;
    r.ph = 0; r.cur = n - 1; r.cnt = AT; r.blink = 0; r.held = 0;
    return r;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t m, input int n, input bit nt,
                                    input bit em_in, input int ed);
    mdl_t r;
    bit em;
    bit done;
    r = m;
    em = em_in && (ed < n);
    done = (m.cnt <= 1);
    if (m.ph == 0) begin
      if (!done) r.cnt = m.cnt - 1;
      else if (em) begin r.ph = 1; r.cur = ed; r.cnt = GT; end
      else if (nt) begin r.ph = 3; r.cnt = 0; r.blink = 1; end
      else begin r.ph = 1; r.cur = (m.cur + 1) % n; r.cnt = GT; end
    end else if (m.ph == 1) begin
      if (em && ed == m.cur) r.held = 1;
      else if (em || nt) begin r.ph = 2; r.cnt = YT; r.held = 0; end
      else if (m.held != 0) begin r.cnt = GT; r.held = 0; end
      else if (!done) r.cnt = m.cnt - 1;
      else begin r.ph = 2; r.cnt = YT; end
    end else if (m.ph == 2) begin
      if (!done) r.cnt = m.cnt - 1;
      else begin r.ph = 0; r.cnt = AT; end
    end else begin
      if (em || !nt) begin r.ph = 0; r.cnt = AT; r.cur = n - 1; r.blink = 0; end
      else r.blink = 1 - m.blink;
    end
    return r;
  endfunction

  function automatic int exp_tf(input mdl_t m, input int d);
    if (m.ph == 3) return (m.blink != 0) ? 3'b010 : 3'b000;
    if (d == m.cur && m.ph == 1) return 3'b001;
    if (d == m.cur && m.ph == 2) return 3'b010;
    return 3'b100;
  endfunction

  function automatic int exp_tm(input mdl_t m, input int n, input int d);
    int v;
    v = 0;
    if (m.ph == 3) v = 0;
    else if (d == m.cur && m.ph != 0) v = m.cnt;
    else if (d == (m.cur + 1) % n) v = m.cnt + ((m.ph == 1) ? YT + AT : (m.ph == 2) ? AT : 0);
    return (v > 127) ? 127 : v;
  endfunction

  task automatic cmp_model(input string tag, input mdl_t m, input int n, input logic [11:0] tf,
                           input logic [27:0] tm, input logic [1:0] ph, input logic [1:0] cd);
    int nonred;
    nonred = 0;
    chk({tag, " phase"}, int'(ph), m.ph);
    chk({tag, " cur"}, int'(cd), m.cur);
    for (int d = 0; d < n; d++) begin
      chk($sformatf("%s tf%0d", tag, d), int'(tf[3*d +: 3]), exp_tf(m, d));
      chk($sformatf("%s timer%0d", tag, d), int'(tm[7*d +: 7]), exp_tm(m, n, d));
      if (tf[3*d +: 3] != 3'b100) nonred++;
    end
    if (ph != 2'd3) chk({tag, " single non-red"}, int'(nonred <= 1), 1);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic tick_n(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk); tick = 1'b1;
      @(negedge clk); tick = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic model_ticks(input int k, input bit nt, input bit em, input int ed);
    night = nt; emg = em; emg_dir = 2'(ed);
    for (int i = 0; i < k; i++) begin
      @(negedge clk); tick = 1'b1;
      @(negedge clk); tick = 1'b0;
      m2 = mdl_step(m2, 2, nt, em, ed);
      m3 = mdl_step(m3, 3, nt, em, ed);
      cmp_model("n2", m2, 2, {6'b0, tf2}, {14'b0, tm2}, ph2, cd2);
      cmp_model("n3", m3, 3, {3'b0, tf3}, {7'b0, tm3}, ph3, cd3);
      repeat (2) @(negedge clk);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int gidx[$];
    int gdir[$];
    int prev_ph;

    //           night emg edir n   tf        t0  t1  ph cur
    vt[0]  = '{1'b0, 1'b0, 0, 2,  6'b100001, 30, 35, 1, 0};
    vt[1]  = '{1'b0, 1'b0, 0, 10, 6'b100001, 20, 25, 1, 0};
    vt[2]  = '{1'b0, 1'b1, 1, 1,  6'b100010, 3,  5,  2, 0};
    vt[3]  = '{1'b0, 1'b1, 1, 3,  6'b100100, 0,  2,  0, 0};
    vt[4]  = '{1'b0, 1'b1, 1, 2,  6'b001100, 35, 30, 1, 1};
    vt[5]  = '{1'b0, 1'b1, 1, 50, 6'b001100, 35, 30, 1, 1};
    vt[6]  = '{1'b0, 1'b0, 1, 1,  6'b001100, 35, 30, 1, 1};
    vt[7]  = '{1'b0, 1'b0, 1, 1,  6'b001100, 34, 29, 1, 1};
    vt[8]  = '{1'b1, 1'b0, 0, 1,  6'b010100, 5,  3,  2, 1};
    vt[9]  = '{1'b1, 1'b0, 0, 2,  6'b010100, 3,  1,  2, 1};
    vt[10] = '{1'b1, 1'b0, 0, 1,  6'b100100, 2,  0,  0, 1};
    vt[11] = '{1'b1, 1'b0, 0, 2,  6'b010010, 0,  0,  3, 1};
    vt[12] = '{1'b1, 1'b0, 0, 1,  6'b000000, 0,  0,  3, 1};
    vt[13] = '{1'b1, 1'b0, 0, 1,  6'b010010, 0,  0,  3, 1};
    vt[14] = '{1'b0, 1'b0, 0, 1,  6'b100100, 2,  0,  0, 1};
    vt[15] = '{1'b0, 1'b0, 0, 2,  6'b100001, 30, 35, 1, 0};
    vt[16] = '{1'b1, 1'b1, 1, 1,  6'b100010, 3,  5,  2, 0};
    vt[17] = '{1'b1, 1'b1, 1, 3,  6'b100100, 0,  2,  0, 0};
    vt[18] = '{1'b1, 1'b1, 1, 2,  6'b001100, 35, 30, 1, 1};
    vt[19] = '{1'b1, 1'b1, 1, 20, 6'b001100, 35, 30, 1, 1};
    vt[20] = '{1'b1, 1'b0, 1, 1,  6'b010100, 5,  3,  2, 1};
    vt[21] = '{1'b1, 1'b1, 3, 3,  6'b100100, 2,  0,  0, 1};
    vt[22] = '{1'b1, 1'b1, 3, 2,  6'b010010, 0,  0,  3, 1};
    vt[23] = '{1'b0, 1'b1, 0, 1,  6'b100100, 2,  0,  0, 1};
    vt[24] = '{1'b0, 1'b1, 0, 2,  6'b100001, 30, 35, 1, 0};
    vt[25] = '{1'b0, 1'b1, 2, 1,  6'b100001, 29, 34, 1, 0};

    do_reset();
    chk("reset tf2", int'(tf2), 6'b100100);
    chk("reset timer2", int'(tm2), 2);
    chk("reset phase2", int'(ph2), 0);
    chk("reset cur2", int'(cd2), 1);
    chk("reset tf3", int'(tf3), 9'b100100100);
    chk("reset timer3", int'(tm3), 2);
    chk("reset cur3", int'(cd3), 2);

    for (int i = 0; i < 26; i++) begin
      night = vt[i].night; emg = vt[i].emg; emg_dir = 2'(vt[i].edir);
      tick_n(vt[i].n);
      chk($sformatf("vec%0d tf", i), int'(tf2), vt[i].tf);
      chk($sformatf("vec%0d timer0", i), int'(tm2[6:0]), vt[i].t0);
      chk($sformatf("vec%0d timer1", i), int'(tm2[13:7]), vt[i].t1);
      chk($sformatf("vec%0d phase", i), int'(ph2), vt[i].ph);
      chk($sformatf("vec%0d cur", i), int'(cd2), vt[i].cur);
    end

    // Reset asserted between edges during yellow, then idle with TICK low.
    night = 1'b0; emg = 1'b0; emg_dir = 2'd0;
    do_reset();
    tick_n(32);
    chk("pre-rst phase", int'(ph2), 2);
    chk("pre-rst timer0", int'(tm2[6:0]), 3);
    @(posedge clk); #2; rst = 1'b1; #1;
    chk("async rst tf", int'(tf2), 6'b100100);
    chk("async rst timer", int'(tm2), 2);
    chk("async rst phase", int'(ph2), 0);
    #4; rst = 1'b0;
    night = 1'b1; emg = 1'b1;
    repeat (12) @(negedge clk);
    chk("no-tick phase", int'(ph2), 0);
    chk("no-tick cur", int'(cd2), 1);
    chk("no-tick timer", int'(tm2), 2);

    // Full 3-direction cycle with model comparison and green ordering.
    do_reset();
    m2 = mdl_reset(2);
    m3 = mdl_reset(3);
    prev_ph = 0;
    for (int t = 1; t <= 110; t++) begin
      model_ticks(1, 1'b0, 1'b0, 0);
      if (ph3 == 2'd1 && prev_ph != 1) begin
        gidx.push_back(t);
        gdir.push_back(int'(cd3));
      end
      prev_ph = int'(ph3);
    end
    chk("green starts", gidx.size(), 4);
    if (gidx.size() == 4) begin
      chk("green order 0", gdir[0], 0);
      chk("green order 1", gdir[1], 1);
      chk("green order 2", gdir[2], 2);
      chk("green order 3", gdir[3], 0);
      chk("cycle period", gidx[3] - gidx[0], 105);
    end

    // Randomized request patterns.
    for (int s = 0; s < 50; s++) begin
      model_ticks($urandom_range(1, 25), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 4) == 0), $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tf_ctl_multi.md
Name: tf_ctl_multi

Overview:
- Parametrised successor to the two-way traffic-light controller: sequences N_DIR approaches round-robin through GREEN, YELLOW and ALL-RED.
- Drives per-direction lamp codes and countdown displays.
- Adds night flashing-yellow mode and an emergency-preemption hold.
- Sits between the 1 Hz tick generator and the 7-segment and lamp drivers.

Parameters:
- N_DIR, 2: number of approaches, legal range 2..4.
- TW, 7: countdown width in bits.
- GREEN_T, 30: green duration in ticks.
- YELLOW_T, 3: yellow duration in ticks.
- ALLRED_T, 2: all-red clearance duration in ticks.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-high reset.
- TICK  in  1  one-CLK-wide timebase strobe (1 Hz in system).
- NIGHT  in  1  level request for flashing-yellow mode.
- EMG  in  1  level request for emergency preemption.
- EMG_DIR  in  2  direction to grant under EMG; values >= N_DIR are ignored (treated as EMG=0).
- TF  out  3*N_DIR  lamps per direction d at [3d+2:3d] = {R,Y,G}: 100 red, 010 yellow, 001 green, 000 dark.
- TIMER  out  TW*N_DIR  countdown per direction at [TW*d+TW-1:TW*d].
- PHASE  out  2  0=ALLRED, 1=GREEN, 2=YELLOW, 3=NIGHT.
- CUR_DIR  out  2  direction owning the current or last green.

Behaviour:
- Registers:
  - state: ALLRED / GREEN / YELLOW / NIGHT.
  - cur: direction.
  - cnt: TW bits.
  - blink: 1 bit.
- Reset values:
  - state=ALLRED, cur=N_DIR-1, cnt=ALLRED_T, blink=0.
  - All TF=100.
  - TIMER[0]=ALLRED_T; all other TIMER=0.
- Timing:
  - All state changes occur only on a CLK edge with TICK=1.
  - With TICK=0 every register holds.
  - Outputs are combinational from registers, so there is zero latency after the edge.
- Countdown on each TICK:
  - cnt>1: decrement.
  - cnt==1: leave the state and load the next state's duration.
- Normal sequence: GREEN(cur) -> YELLOW(cur) -> ALLRED -> GREEN(cur+1 mod N_DIR).
- Lamps:
  - Direction cur shows 001 in GREEN and 010 in YELLOW.
  - All other directions show 100.
- TIMER display:
  - Direction cur in GREEN/YELLOW: cnt.
  - Next direction n=(cur+1 mod N_DIR): cnt+YELLOW_T+ALLRED_T in GREEN, cnt+ALLRED_T in YELLOW, cnt in ALLRED.
  - All other directions: 0.
  - Saturate at 2^TW-1.
- EMG (priority over NIGHT), evaluated at each TICK:
  - GREEN with cur==EMG_DIR: hold; cnt frozen.
  - GREEN with cur!=EMG_DIR: go to YELLOW immediately, cnt=YELLOW_T.
  - YELLOW: runs out normally.
  - ALLRED: on expiry, next green is EMG_DIR instead of cur+1.
  - NIGHT: go to ALLRED, cnt=ALLRED_T.
  - Release: a held GREEN reloads GREEN_T and resumes normal sequencing.
- NIGHT (EMG=0):
  - GREEN: forced to YELLOW (cnt=YELLOW_T), then ALLRED.
  - ALLRED expiry with NIGHT high enters NIGHT.
  - In NIGHT:
    - All TF = blink ? 010 : 000.
    - blink toggles each TICK.
    - All TIMER=0, cnt=0.
  - NIGHT dropped: ALLRED with cnt=ALLRED_T, cur=N_DIR-1, so green restarts at direction 0.
- Exactly one direction may ever be non-red outside NIGHT.
- No direction ever goes green directly from another direction's green or yellow.
- RST mid-operation: immediate return to reset values, independent of CLK.
- Duration parameters are >=1 and <2^TW; this is enforced by elaboration-time check.

Decomposition:
- Package tf_pkg:
  - state enum: ALLRED=0, GREEN=1, YELLOW=2, NIGHT=3.
  - Lamp constants: LAMP_R, LAMP_Y, LAMP_G, LAMP_OFF.
  - Saturating-add function.
- One sub-module, tf_display_map: combinational mapping of state/cur/cnt to the TF and TIMER vectors, reused by future pedestrian variants.
- FSM and counter stay in the top-level module.

Test Plan:
1. Defaults, TICK every 4 CLK, RST pulse:
   - After reset: TF0=100, TF1=100, TIMER0=2.
   - After 2 ticks: TF0=001, TIMER0=30, TIMER1=35.
   - After 30 more ticks: TF0=010, TIMER0=3.
2. Full cycle, N_DIR=3:
   - Green order 0,1,2,0.
   - Period of 105 ticks.
   - Assert every cycle: at most one non-100 lamp.
3. EMG=1, EMG_DIR=1 while dir 0 is GREEN with cnt=20:
   - Next tick: YELLOW(0) with cnt=3.
   - Then ALLRED for 2 ticks, then GREEN(1) held for 50 ticks with TIMER1 frozen at 30.
   - Release: countdown resumes from 30.
4. NIGHT=1 during GREEN:
   - YELLOW 3 ticks, ALLRED 2 ticks, then all TF alternate 010/000 per tick.
   - NIGHT=0: ALLRED 2 ticks, then GREEN(0).
5. EMG and NIGHT asserted together: EMG behaviour wins; no NIGHT entry until EMG drops.
6. RST asserted mid-YELLOW between CLK edges: outputs return to reset values before the next CLK edge; TICK held 0 causes no state change.
